// File: rtl/pipeline_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_mem_arbiter_if
// Purpose  : Bus bundle between the pipeline (IF and MEM stages), the memory
//            arbiter and the single-port memory wrapper.
// Signals  : if_*  fetch request/response
//            dm_*  load/store request/response
//            mem_* single-port memory strobe, address, data
// Modports : slave  - arbiter view (requests in, responses and mem_* out)
//            master - requester/memory view (the mirror of slave)
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   // Load/store side
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   // Memory side
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_valid,
      output dm_rdata, dm_valid,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_valid,
      input  dm_rdata, dm_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_mem_arbiter
// Purpose  : Shares one fixed-latency single-port memory between instruction
//            fetch and load/store. Loads/stores win over fetches; an in-flight
//            access always runs to completion. Drives the pipeline register
//            enables so no stage advances past an incomplete access.
// Ports    : clk                  rising-edge clock
//            rst_n                asynchronous active-low reset
//            bus (slave)          fetch, load/store and memory signals
//            PC_Write, if_id_Write, id_ex_Write, ex_mem_Write
//                                 pipeline register write enables
//            id_ex_cntrl_mux_sel  1 = inject a nop into ID/EX
// Params   : ADDR_W, DATA_W, MEM_LAT (issue edge to mem_rdata, 1..15)
// Revision : 1.0  initial release
// ============================================================================
module pipeline_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_mem_arbiter_if.slave bus,
   output logic                  PC_Write,
   output logic                  if_id_Write,
   output logic                  id_ex_Write,
   output logic                  ex_mem_Write,
   output logic                  id_ex_cntrl_mux_sel
);

   localparam int               CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(MEM_LAT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               kill_q,  kill_d;    // in-flight fetch was flushed
   logic               store_q, store_d;   // in-flight data access is a store

   logic               issue_en;
   logic               issue_we;
   logic [ADDR_W-1:0]  issue_addr;
   logic [DATA_W-1:0]  issue_wdata;
   logic               if_done;
   logic               dm_done;
   logic               fetch_busy;
   logic               fetch_hold;
   logic               data_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         kill_q  <= 1'b0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         store_q <= store_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      kill_d      = kill_q;
      store_d     = store_q;
      issue_en    = 1'b0;
      issue_we    = 1'b0;
      issue_addr  = '0;
      issue_wdata = '0;
      if_done     = 1'b0;
      dm_done     = 1'b0;
      fetch_busy  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.dm_req) begin
               issue_en    = 1'b1;
               issue_we    = bus.dm_we;
               issue_addr  = bus.dm_addr;
               issue_wdata = bus.dm_wdata;
               store_d     = bus.dm_we;
               cnt_d       = CNT_ONE;
               state_d     = DM_BUSY;
            end else if (bus.if_req) begin
               issue_en    = 1'b1;
               issue_addr  = bus.if_addr;
               // A flush coinciding with the issue already kills this fetch.
               kill_d      = bus.if_flush;
               cnt_d       = CNT_ONE;
               fetch_busy  = 1'b1;
               state_d     = IF_BUSY;
            end
         end
         IF_BUSY: begin
            if (cnt_q == CNT_LAT) begin
               if_done = 1'b1;
               kill_d  = 1'b0;
               cnt_d   = CNT_ZERO;
               state_d = IDLE;
            end else begin
               kill_d     = kill_q | bus.if_flush;
               cnt_d      = cnt_q + CNT_ONE;
               fetch_busy = 1'b1;
            end
         end
         DM_BUSY: begin
            // Stores retire one cycle after issue whatever the read latency.
            if (store_q ? (cnt_q == CNT_ONE) : (cnt_q == CNT_LAT)) begin
               dm_done = 1'b1;
               cnt_d   = CNT_ZERO;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            kill_d  = 1'b0;
         end
      endcase
   end

   // A pending load/store freezes the whole pipeline, even while a fetch is
   // still draining, until the data access itself completes. Reset releases
   // every hold regardless of the request levels.
   assign fetch_hold = rst_n & fetch_busy;
   assign data_hold  = rst_n & bus.dm_req & ~dm_done;

   always_comb begin
      PC_Write            = 1'b1;
      if_id_Write         = 1'b1;
      id_ex_Write         = 1'b1;
      ex_mem_Write        = 1'b1;
      id_ex_cntrl_mux_sel = 1'b0;
      if (data_hold) begin
         PC_Write     = 1'b0;
         if_id_Write  = 1'b0;
         id_ex_Write  = 1'b0;
         ex_mem_Write = 1'b0;
      end else if (fetch_hold) begin
         PC_Write            = 1'b0;
         if_id_Write         = 1'b0;
         id_ex_cntrl_mux_sel = 1'b1;
      end
   end

   // Issue is combinational from requests in IDLE, so it must be masked while
   // reset is asserted to keep the memory quiet.
   assign bus.mem_en    = rst_n & issue_en;
   assign bus.mem_we    = rst_n & issue_we;
   assign bus.mem_addr  = issue_addr;
   assign bus.mem_wdata = issue_wdata;

   assign bus.if_valid  = rst_n & if_done & ~kill_q & ~bus.if_flush;
   assign bus.dm_valid  = rst_n & dm_done;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.dm_rdata  = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_mem_arbiter
// Purpose  : Directed self-checking bench for pipeline_mem_arbiter with a
//            fixed-latency memory model and a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_mem_arbiter;

   localparam int         LAT   = 3;
   localparam logic [4:0] RUN   = 5'b11110;  // {PC, IF/ID, ID/EX, EX/MEM, nop}
   localparam logic [4:0] FHOLD = 5'b00111;
   localparam logic [4:0] DHOLD = 5'b00000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        PC_Write, if_id_Write, id_ex_Write, ex_mem_Write, id_ex_cntrl_mux_sel;
   logic [4:0]  stall;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   logic [31:0] m_addr = '0;
   int          m_age  = 0;

   pipeline_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   pipeline_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .bus                 (bus),
      .PC_Write            (PC_Write),
      .if_id_Write         (if_id_Write),
      .id_ex_Write         (id_ex_Write),
      .ex_mem_Write        (ex_mem_Write),
      .id_ex_cntrl_mux_sel (id_ex_cntrl_mux_sel)
   );

   always #5 clk = ~clk;

   assign stall = {PC_Write, if_id_Write, id_ex_Write, ex_mem_Write, id_ex_cntrl_mux_sel};

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h10) return 32'h00A00093;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory model: data is valid only exactly LAT cycles after the issue edge.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         m_addr <= bus.mem_addr;
         m_age  <= 1;
      end else if (m_age < 100) begin
         m_age  <= m_age + 1;
      end
   end
   assign bus.mem_rdata = (m_age == LAT) ? mem_fn(m_addr) : 32'hBAD0BAD0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic chk_st(input string tag, input logic [4:0] exp);
      chk(tag, {27'd0, stall}, {27'd0, exp});
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Scoreboard: every completed fetch/load is compared with the oldest entry.
   always @(negedge clk) begin
      if (bus.if_valid) begin
         if (exp_if_q.size() == 0) chk1("if_valid_unexpected", bus.if_valid, 1'b0);
         else                      chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
      end
      if (bus.dm_valid && !bus.dm_we) begin
         if (exp_dm_q.size() == 0) chk1("dm_valid_unexpected", bus.dm_valid, 1'b0);
         else                      chk("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.if_req = 1'b1; bus.if_addr = 32'h10; bus.if_flush = 1'b0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h50; bus.dm_wdata = '0;

      // Reset with both requests asserted
      #12;
      chk1("rst_mem_en", bus.mem_en, 1'b0);
      chk1("rst_mem_we", bus.mem_we, 1'b0);
      chk1("rst_if_valid", bus.if_valid, 1'b0);
      chk1("rst_dm_valid", bus.dm_valid, 1'b0);
      chk_st("rst_stall", RUN);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      nxt(); rst_n = 1'b1;

      // Fetch only: issue c0, complete c3, back-to-back issue c4
      nxt(); bus.if_req = 1'b1; bus.if_addr = 32'h10; exp_if_q.push_back(32'h00A00093);
      mid(); chk1("f_c0_en", bus.mem_en, 1'b1); chk1("f_c0_we", bus.mem_we, 1'b0);
             chk("f_c0_addr", bus.mem_addr, 32'h10); chk_st("f_c0_stall", FHOLD);
      nxt(); mid(); chk1("f_c1_en", bus.mem_en, 1'b0); chk_st("f_c1_stall", FHOLD);
      nxt(); mid(); chk1("f_c2_valid", bus.if_valid, 1'b0); chk_st("f_c2_stall", FHOLD);
      nxt(); mid(); chk1("f_c3_valid", bus.if_valid, 1'b1); chk_st("f_c3_stall", RUN);
             chk1("f_c3_en", bus.mem_en, 1'b0);
      nxt(); bus.if_addr = 32'h14; exp_if_q.push_back(mem_fn(32'h14));
      mid(); chk1("f_c4_en", bus.mem_en, 1'b1); chk("f_c4_addr", bus.mem_addr, 32'h14);
      nxt(); nxt(); mid(); chk1("f_c6_valid", bus.if_valid, 1'b0);
      nxt(); mid(); chk1("f_c7_valid", bus.if_valid, 1'b1);

      // Both requests: load first, fetch after load completion
      nxt(); bus.if_addr = 32'h20;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40; exp_dm_q.push_back(mem_fn(32'h40));
      mid(); chk1("b_c0_en", bus.mem_en, 1'b1); chk("b_c0_addr", bus.mem_addr, 32'h40);
             chk_st("b_c0_stall", DHOLD);
      nxt(); mid(); chk1("b_c1_en", bus.mem_en, 1'b0); chk_st("b_c1_stall", DHOLD);
      nxt(); mid(); chk1("b_c2_dvalid", bus.dm_valid, 1'b0); chk_st("b_c2_stall", DHOLD);
      nxt(); mid(); chk1("b_c3_dvalid", bus.dm_valid, 1'b1); chk_st("b_c3_stall", RUN);
             chk1("b_c3_en", bus.mem_en, 1'b0);
      nxt(); bus.dm_req = 1'b0; exp_if_q.push_back(mem_fn(32'h20));
      mid(); chk1("b_c4_en", bus.mem_en, 1'b1); chk("b_c4_addr", bus.mem_addr, 32'h20);
             chk_st("b_c4_stall", FHOLD);
      nxt(); nxt(); nxt(); mid(); chk1("b_c7_ivalid", bus.if_valid, 1'b1);

      // Store completes one cycle after issue, next load issues at c2
      nxt(); bus.if_req = 1'b0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h44; bus.dm_wdata = 32'hDEADBEEF;
      mid(); chk1("s_c0_en", bus.mem_en, 1'b1); chk1("s_c0_we", bus.mem_we, 1'b1);
             chk("s_c0_addr", bus.mem_addr, 32'h44); chk("s_c0_wdata", bus.mem_wdata, 32'hDEADBEEF);
             chk_st("s_c0_stall", DHOLD);
      nxt(); mid(); chk1("s_c1_dvalid", bus.dm_valid, 1'b1); chk_st("s_c1_stall", RUN);
      nxt(); bus.dm_we = 1'b0; bus.dm_addr = 32'h48; exp_dm_q.push_back(mem_fn(32'h48));
      mid(); chk1("s_c2_en", bus.mem_en, 1'b1); chk1("s_c2_we", bus.mem_we, 1'b0);
      nxt(); nxt(); nxt(); mid(); chk1("s_c5_dvalid", bus.dm_valid, 1'b1);

      // Flush during an in-flight fetch
      nxt(); bus.dm_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h80;
      mid(); chk1("k_c0_en", bus.mem_en, 1'b1); chk_st("k_c0_stall", FHOLD);
      nxt(); bus.if_flush = 1'b1; bus.if_addr = 32'h90;
      mid(); chk1("k_c1_en", bus.mem_en, 1'b0); chk_st("k_c1_stall", FHOLD);
      nxt(); bus.if_flush = 1'b0;
      mid(); chk_st("k_c2_stall", FHOLD);
      nxt(); mid(); chk1("k_c3_ivalid", bus.if_valid, 1'b0); chk_st("k_c3_stall", RUN);
      nxt(); exp_if_q.push_back(mem_fn(32'h90));
      mid(); chk1("k_c4_en", bus.mem_en, 1'b1); chk("k_c4_addr", bus.mem_addr, 32'h90);
      nxt(); nxt(); nxt(); mid(); chk1("k_c7_ivalid", bus.if_valid, 1'b1);

      // Flush in the issue cycle, then flush in the completion cycle
      nxt(); bus.if_addr = 32'hA0; bus.if_flush = 1'b1;
      mid(); chk1("ki_c0_en", bus.mem_en, 1'b1);
      nxt(); bus.if_flush = 1'b0;
      nxt(); nxt(); mid(); chk1("ki_c3_ivalid", bus.if_valid, 1'b0);
      nxt(); bus.if_addr = 32'hB0;
      mid(); chk1("kc_c0_en", bus.mem_en, 1'b1);
      nxt(); nxt(); nxt(); bus.if_flush = 1'b1;
      mid(); chk1("kc_c3_ivalid", bus.if_valid, 1'b0); chk_st("kc_c3_stall", RUN);

      // Flush in IDLE with no fetch has no effect on the next fetch
      nxt(); bus.if_req = 1'b0;
      mid(); chk1("ki_idle_en", bus.mem_en, 1'b0); chk_st("ki_idle_stall", RUN);

      // Load arrives during a fetch: fetch drains, then load, full freeze
      nxt(); bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'hC0;
      exp_if_q.push_back(mem_fn(32'hC0));
      mid(); chk1("d_c0_en", bus.mem_en, 1'b1); chk_st("d_c0_stall", FHOLD);
      nxt(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4C;
      mid(); chk1("d_c1_en", bus.mem_en, 1'b0); chk_st("d_c1_stall", DHOLD);
      nxt(); mid(); chk_st("d_c2_stall", DHOLD);
      nxt(); mid(); chk1("d_c3_ivalid", bus.if_valid, 1'b1); chk_st("d_c3_stall", DHOLD);
      nxt(); bus.if_req = 1'b0; exp_dm_q.push_back(mem_fn(32'h4C));
      mid(); chk1("d_c4_en", bus.mem_en, 1'b1); chk("d_c4_addr", bus.mem_addr, 32'h4C);
             chk_st("d_c4_stall", DHOLD);
      nxt(); nxt(); mid(); chk_st("d_c6_stall", DHOLD);
      nxt(); mid(); chk1("d_c7_dvalid", bus.dm_valid, 1'b1); chk_st("d_c7_stall", RUN);

      // Reset in the middle of a load; held request re-issues after release
      nxt(); bus.dm_addr = 32'h50;
      mid(); chk1("r_c0_en", bus.mem_en, 1'b1);
      nxt(); rst_n = 1'b0; #1;
      chk1("r_mid_en", bus.mem_en, 1'b0); chk1("r_mid_dvalid", bus.dm_valid, 1'b0);
      chk_st("r_mid_stall", RUN);
      nxt(); rst_n = 1'b1; exp_dm_q.push_back(mem_fn(32'h50));
      mid(); chk1("r_c0b_en", bus.mem_en, 1'b1); chk("r_c0b_addr", bus.mem_addr, 32'h50);
             chk_st("r_c0b_stall", DHOLD);
      nxt(); mid(); chk1("r_c1b_dvalid", bus.dm_valid, 1'b0);
      nxt(); mid(); chk1("r_c2b_dvalid", bus.dm_valid, 1'b0);
      nxt(); mid(); chk1("r_c3b_dvalid", bus.dm_valid, 1'b1);
      nxt(); bus.dm_req = 1'b0;
      mid(); chk1("end_en", bus.mem_en, 1'b0);

      nxt();
      chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
      chk("dm_queue_drained", 32'(exp_dm_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
